// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated with idle gaps.
// Optional even-parity bit per frame when SERIAL_TX_PARITY_EN is defined.
module serial_pattern_tx #(
   parameter int PAT_W = 6,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [CNT_W-1:0] gap_len,
   output logic             busy,
   output logic             d_out,
   output logic             frame_valid,
   output logic             done
);

   localparam int IDX_W = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

   typedef enum logic [2:0] {IDLE, SHIFT, PAR, GAP, DONE} state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [CNT_W-1:0] frames_left, frames_n;
   logic [CNT_W-1:0] gap_cnt, gap_cnt_n;
   logic [CNT_W-1:0] gap_q, gap_q_n;
   logic [PAT_W-1:0] pat_q, pat_n;
   logic             d_n, fv_n, busy_n, done_n;
   logic             frame_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         frames_left <= '0;
         gap_cnt     <= '0;
         gap_q       <= '0;
         pat_q       <= '0;
         d_out       <= 1'b0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         frames_left <= frames_n;
         gap_cnt     <= gap_cnt_n;
         gap_q       <= gap_q_n;
         pat_q       <= pat_n;
         d_out       <= d_n;
         frame_valid <= fv_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

   // Outputs are computed for the state being entered, so every output is a flop.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      frames_n  = frames_left;
      gap_cnt_n = gap_cnt;
      gap_q_n   = gap_q;
      pat_n     = pat_q;
      d_n       = 1'b0;
      fv_n      = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      frame_end = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               pat_n    = pattern_in;
               frames_n = repeat_cnt;
               gap_q_n  = gap_len;
               idx_n    = MSB_IDX;
               state_n  = SHIFT;
               d_n      = pattern_in[PAT_W-1];
               fv_n     = 1'b1;
               busy_n   = 1'b1;
            end
         end
         SHIFT: begin
            if (idx != '0) begin
               idx_n  = idx - IDX_W'(1);
               d_n    = pat_q[idx_n];
               fv_n   = 1'b1;
               busy_n = 1'b1;
            end else begin
`ifdef SERIAL_TX_PARITY_EN
               state_n = PAR;
               d_n     = ^pat_q;
               fv_n    = 1'b1;
               busy_n  = 1'b1;
`else
               frame_end = 1'b1;
`endif
            end
         end
         PAR: frame_end = 1'b1;
         GAP: begin
            busy_n = 1'b1;
            if (gap_cnt != '0) begin
               gap_cnt_n = gap_cnt - CNT_W'(1);
            end else begin
               state_n = SHIFT;
               idx_n   = MSB_IDX;
               d_n     = pat_q[PAT_W-1];
               fv_n    = 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      if (frame_end) begin
         busy_n = 1'b1;
         if (frames_left != '0) begin
            frames_n = frames_left - CNT_W'(1);
            if (gap_q != '0) begin
               state_n   = GAP;
               gap_cnt_n = gap_q - CNT_W'(1);
            end else begin
               state_n = SHIFT;
               idx_n   = MSB_IDX;
               d_n     = pat_q[PAT_W-1];
               fv_n    = 1'b1;
            end
         end else begin
            state_n = DONE;
            done_n  = 1'b1;
         end
      end
   end

endmodule
